// File: rtl/frame_replay_if.sv
// Port bundle for frame_replay: record stream, replay request/status and replay AXIS output.
// m_axis_tready exists only when FRAME_REPLAY_TREADY_EN is defined.
interface frame_replay_if #(
  parameter int DW = 16,
  parameter int AW = 10
);
  logic          s_axis_tvalid;
  logic [DW-1:0] s_axis_tdata;
  logic          i_req;
  logic [AW-1:0] i_req_len;
  logic          o_busy;
  logic          o_req_err;
  logic          o_overrun;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [AW-1:0] m_axis_tuser;
`ifdef FRAME_REPLAY_TREADY_EN
  logic          m_axis_tready;
`endif

  // master: the replay block itself; slave: the surrounding source/consumer.
  modport master (
    input  s_axis_tvalid, s_axis_tdata, i_req, i_req_len,
`ifdef FRAME_REPLAY_TREADY_EN
    input  m_axis_tready,
`endif
    output o_busy, o_req_err, o_overrun,
    output m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tuser
  );

  modport slave (
    output s_axis_tvalid, s_axis_tdata, i_req, i_req_len,
`ifdef FRAME_REPLAY_TREADY_EN
    output m_axis_tready,
`endif
    input  o_busy, o_req_err, o_overrun,
    input  m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tuser
  );
endinterface

// File: rtl/frame_replay.sv
// Circular sample recorder that replays the latest L samples as one AXIS frame.
// Optional FRAME_REPLAY_TREADY_EN adds tready backpressure and overrun detection.
module frame_replay #(
  parameter int PAR_DATA_WIDTH = 16,
  parameter int PAR_ADDR_WIDTH = 10
) (
  input  logic           i_clk,
  input  logic           i_rst,
  frame_replay_if.master bus
);
  localparam int DEPTH = 2**PAR_ADDR_WIDTH;
  localparam int AW    = PAR_ADDR_WIDTH;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t                    state_q, state_d;
  logic [PAR_DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]             wr_ptr, fill, rd_ptr, len_q, iss_k;
  logic                      accept, reject, issue, xfer_last, rdy;
  logic                      tvalid_q, tlast_q;
  logic [PAR_DATA_WIDTH-1:0] tdata_q;
  logic [AW-1:0]             tuser_q;
  logic                      req_err_q;

`ifdef FRAME_REPLAY_TREADY_EN
  assign rdy = bus.m_axis_tready;
`else
  assign rdy = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // iss_k counts beats already read from RAM; a new read only when the output slot frees.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    reject    = 1'b0;
    issue     = 1'b0;
    xfer_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_req) begin
          if (bus.i_req_len != '0 && bus.i_req_len <= fill) begin
            accept  = 1'b1;
            state_d = PLAY;
          end else begin
            reject  = 1'b1;
          end
        end
      end
      PLAY: begin
        issue     = (iss_k != len_q) && (!tvalid_q || rdy);
        xfer_last = tvalid_q && rdy && tlast_q;
        if (xfer_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffer and read register carry no reset so they map onto block RAM.
  always_ff @(posedge i_clk) begin
    if (bus.s_axis_tvalid) mem[wr_ptr] <= bus.s_axis_tdata;
    if (issue) begin
      tdata_q <= mem[rd_ptr + iss_k];
      tuser_q <= iss_k;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      fill      <= '0;
      rd_ptr    <= '0;
      len_q     <= '0;
      iss_k     <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      req_err_q <= 1'b0;
    end else begin
      req_err_q <= reject;
      if (bus.s_axis_tvalid) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill != AW'(DEPTH-1)) fill <= fill + 1'b1;
      end
      if (accept) begin
        rd_ptr <= wr_ptr - bus.i_req_len;
        len_q  <= bus.i_req_len;
        iss_k  <= '0;
      end
      if (issue) begin
        iss_k    <= iss_k + 1'b1;
        tvalid_q <= 1'b1;
        tlast_q  <= (iss_k == len_q - 1'b1);
      end else if (tvalid_q && rdy) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
    end
  end

`ifdef FRAME_REPLAY_TREADY_EN
  // A write is an overrun if it lands in [rd_ptr+iss_k, rd_ptr+len); a read issued
  // this cycle still sees the old word, so that address is already safe.
  logic          overrun_q;
  logic [AW-1:0] wr_off, unread_lo;
  assign wr_off    = wr_ptr - rd_ptr;
  assign unread_lo = iss_k + AW'(issue);

  always_ff @(posedge i_clk) begin
    if (i_rst) overrun_q <= 1'b0;
    else       overrun_q <= bus.s_axis_tvalid && (state_q == PLAY) &&
                            (wr_off >= unread_lo) && (wr_off < len_q);
  end
  assign bus.o_overrun = overrun_q;
`else
  assign bus.o_overrun = 1'b0;
`endif

  assign bus.o_busy        = (state_q == PLAY);
  assign bus.o_req_err     = req_err_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tuser  = tuser_q;
endmodule

// File: tb/tb_frame_replay.sv
// Directed bench for frame_replay with a 16-deep buffer; expected values are hand-derived.
module tb_frame_replay;
  localparam int DW = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   rdy = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   nb;
  int   got_d [32];
  int   got_u [32];
  int   got_l [32];

  always #5 clk = ~clk;

  frame_replay_if #(.DW(DW), .AW(AW)) bus ();
`ifdef FRAME_REPLAY_TREADY_EN
  assign bus.m_axis_tready = rdy;
`endif

  frame_replay #(.PAR_DATA_WIDTH(DW), .PAR_ADDR_WIDTH(AW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic record(input int from, input int to);
    for (int v = from; v <= to; v++) begin
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = DW'(v);
      tick();
    end
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic do_req(input int len);
    bus.i_req     = 1'b1;
    bus.i_req_len = len[AW-1:0];
    tick();
    bus.i_req     = 1'b0;
  endtask

  task automatic collect(input int ncyc, input bit tog);
    for (int c = 0; c < ncyc; c++) begin
      if (tog) rdy = (c % 2 == 0);
      if (bus.m_axis_tvalid && rdy) begin
        if (nb < 32) begin
          got_d[nb] = int'(bus.m_axis_tdata);
          got_u[nb] = int'(bus.m_axis_tuser);
          got_l[nb] = int'(bus.m_axis_tlast);
        end
        nb++;
      end
      tick();
    end
    rdy = 1'b1;
  endtask

  // Beat 0 carries d0, beat k>0 carries dbase+k; tlast only on the final beat.
  task automatic chk_beats(input string tag, input int len, input int d0, input int dbase);
    int bad_d, bad_u, bad_l;
    bad_d = 0; bad_u = 0; bad_l = 0;
    chk({tag, "_nbeats"}, nb, len);
    for (int k = 0; k < len && k < 32; k++) begin
      if (got_d[k] != ((k == 0) ? d0 : dbase + k)) bad_d++;
      if (got_u[k] != k) bad_u++;
      if (got_l[k] != ((k == len - 1) ? 1 : 0)) bad_l++;
    end
    chk({tag, "_data_errs"}, bad_d, 0);
    chk({tag, "_user_errs"}, bad_u, 0);
    chk({tag, "_last_errs"}, bad_l, 0);
  endtask

  initial begin
    int nlast, unstable, nov;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.i_req         = 1'b0;
    bus.i_req_len     = '0;

    // 1: basic replay with exact cycle timing
    do_reset();
    chk("rst_tvalid", bus.m_axis_tvalid, 0);
    chk("rst_tlast",  bus.m_axis_tlast, 0);
    chk("rst_busy",   bus.o_busy, 0);
    chk("rst_err",    bus.o_req_err, 0);
    chk("rst_ovr",    bus.o_overrun, 0);
    record(1, 8);
    do_req(4);
    chk("t1_busy_t1",   bus.o_busy, 1);
    chk("t1_tvalid_t1", bus.m_axis_tvalid, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t1_tvalid", bus.m_axis_tvalid, 1);
      chk("t1_tdata",  bus.m_axis_tdata, 5 + k);
      chk("t1_tuser",  bus.m_axis_tuser, k);
      chk("t1_tlast",  bus.m_axis_tlast, (k == 3) ? 1 : 0);
      tick();
    end
    chk("t1_tvalid_end", bus.m_axis_tvalid, 0);
    chk("t1_busy_end",   bus.o_busy, 0);

    // 2: rejected requests (L > fill, L = 0)
    do_reset();
    record(1, 8);
    do_req(10);
    chk("t2_err_long",  bus.o_req_err, 1);
    chk("t2_busy_long", bus.o_busy, 0);
    tick();
    chk("t2_err_clr",   bus.o_req_err, 0);
    do_req(0);
    chk("t2_err_zero",  bus.o_req_err, 1);
    nb = 0;
    collect(4, 1'b0);
    chk("t2_no_beats",  nb, 0);
    chk("t2_busy",      bus.o_busy, 0);

    // 3: wrap with saturated fill
    do_reset();
    record(0, 39);
    do_req(15);
    nb = 0;
    collect(20, 1'b0);
    chk_beats("t3", 15, 25, 25);
    do_req(16);
    chk("t3_err_16", bus.o_req_err, 1);
    chk("t3_busy_16", bus.o_busy, 0);

    // 4: same-cycle write excluded, mid-frame request ignored
    do_reset();
    record(0, 9);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = DW'(10);
    do_req(5);
    bus.s_axis_tvalid = 1'b0;
    nb = 0;
    collect(2, 1'b0);
    bus.i_req     = 1'b1;
    bus.i_req_len = AW'(3);
    collect(1, 1'b0);
    bus.i_req     = 1'b0;
    chk("t4_no_err", bus.o_req_err, 0);
    collect(10, 1'b0);
    chk_beats("t4", 5, 5, 5);
    nlast = 0;
    for (int k = 0; k < nb && k < 32; k++) nlast += got_l[k];
    chk("t4_nlast", nlast, 1);
    chk("t4_busy_end", bus.o_busy, 0);

    // 5: reset mid-frame truncates and clears fill
    do_reset();
    record(0, 9);
    do_req(8);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("t5_tdata", bus.m_axis_tdata, 2 + k);
      if (k < 2) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_tvalid_rst", bus.m_axis_tvalid, 0);
    chk("t5_busy_rst",   bus.o_busy, 0);
    do_req(1);
    chk("t5_err_empty",  bus.o_req_err, 1);

`ifdef FRAME_REPLAY_TREADY_EN
    // 6: backpressure with recording overwriting unread frame words
    rdy = 1'b0;
    do_reset();
    record(0, 15);
    do_req(8);
    unstable = 0;
    nov = 0;
    for (int i = 0; i < 20; i++) begin
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = DW'(100 + i);
      tick();
      if (bus.o_overrun) nov++;
      if (!bus.m_axis_tvalid || bus.m_axis_tdata != 8 || bus.m_axis_tuser != 0 ||
          bus.m_axis_tlast) unstable++;
    end
    bus.s_axis_tvalid = 1'b0;
    chk("t6_unstable", unstable, 0);
    chk("t6_overruns", nov, 7);
    nb = 0;
    collect(30, 1'b1);
    chk_beats("t6", 8, 8, 108);
    chk("t6_busy_end", bus.o_busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1);
  end
endmodule
